frame_dma: RTL and testbench



---
 rtl/frame_dma.sv | 231 +++++++++++++++++++++++
 tb/tb_frame_dma.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_dma.sv
`timescale 1ns/1ps
// frame_dma: byte-wide Wishbone DMA master that copies or fills a block of bytes,
// programmed through a 16-byte slave register window, with optional frame-sync start.
module frame_dma #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter int                       DATA_WIDTH    = 8,
  parameter int                       DATA_BYTES    = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS  = 'h0020
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // register slave port
  input  logic [ADDRESS_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  input  logic                     we_i,
  input  logic [DATA_BYTES-1:0]    sel_i,
  input  logic                     stb_i,
  input  logic                     cyc_i,
  output logic                     ack_o,
  input  logic [2:0]               cti_i,
  // bus master port
  output logic [ADDRESS_WIDTH-1:0] m_adr_o,
  output logic [DATA_WIDTH-1:0]    m_dat_o,
  input  logic [DATA_WIDTH-1:0]    m_dat_i,
  output logic                     m_we_o,
  output logic [DATA_BYTES-1:0]    m_sel_o,
  output logic                     m_stb_o,
  output logic                     m_cyc_o,
  input  logic                     m_ack_i,
  output logic [2:0]               m_cti_o,
  // frame alignment and completion
  input  logic                     frame_sync,
  output logic                     done_o
);

  localparam int CW = 2 * DATA_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] WIN_MASK = {{(ADDRESS_WIDTH-4){1'b1}}, 4'h0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_READ,
    S_WRITE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t state;

  // programmed registers
  logic [DATA_WIDTH-1:0] src_l, src_h, dst_l, dst_h, cnt_l, cnt_h, fill_val;

  // working copies, advanced as the transfer progresses
  logic [ADDRESS_WIDTH-1:0] src_w, dst_w;
  logic [CW-1:0]            cnt_w;
  logic [DATA_WIDTH-1:0]    data_q;

  logic fill_q, sync_q, done_q;
  logic abort_pend, after_read;

  logic [3:0]            local_adr;
  logic                  valid, access, ctrl_wr, start_req, abort_req, busy;
  logic [DATA_WIDTH-1:0] rdata;

  // classic cycles only; sideband inputs on the slave port carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{sel_i, cti_i};

  assign m_sel_o = '1;
  assign m_cti_o = 3'b000;

  assign local_adr = adr_i[3:0];
  assign valid     = ((adr_i & WIN_MASK) == BASE_ADDRESS) && !local_adr[3];
  assign access    = cyc_i && stb_i && valid && !ack_o;
  assign ctrl_wr   = access && we_i && (local_adr == 4'd0);
  assign busy      = (state != S_IDLE);
  assign start_req = ctrl_wr && dat_i[0] && !busy;
  assign abort_req = ctrl_wr && dat_i[2];

  always_comb begin
    // NOTE: default first so every path assigns rdata and no latch is inferred.
    rdata = '0;
    case (local_adr)
      4'd0:    rdata = DATA_WIDTH'({4'b0000, sync_q, done_q, fill_q, busy});
      4'd1:    rdata = src_l;
      4'd2:    rdata = src_h;
      4'd3:    rdata = dst_l;
      4'd4:    rdata = dst_h;
      4'd5:    rdata = cnt_l;
      4'd6:    rdata = cnt_h;
      4'd7:    rdata = fill_val;
      default: rdata = '0;
    endcase
  end

  // Slave side: one ack per access, read data presented alongside it.
  always_ff @(posedge clk_i) begin
    // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
    if (rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= '0;
      src_l    <= '0;
      src_h    <= '0;
      dst_l    <= '0;
      dst_h    <= '0;
      cnt_l    <= '0;
      cnt_h    <= '0;
      fill_val <= '0;
    end else begin
      ack_o <= cyc_i && stb_i && valid && !ack_o;
      dat_o <= (access && !we_i) ? rdata : '0;
      if (access && we_i && !busy) begin
        case (local_adr)
          4'd1:    src_l    <= dat_i;
          4'd2:    src_h    <= dat_i;
          4'd3:    dst_l    <= dat_i;
          4'd4:    dst_h    <= dat_i;
          4'd5:    cnt_l    <= dat_i;
          4'd6:    cnt_h    <= dat_i;
          4'd7:    fill_val <= dat_i;
          default: ;
        endcase
      end
    end
  end

  // Transfer engine; every master output is a flop set on the transition into its state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_we_o     <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
      done_o     <= 1'b0;
      src_w      <= '0;
      dst_w      <= '0;
      cnt_w      <= '0;
      data_q     <= '0;
      fill_q     <= 1'b0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_pend <= 1'b0;
      after_read <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start_req) begin
            fill_q     <= dat_i[1];
            sync_q     <= dat_i[3];
            done_q     <= 1'b0;
            after_read <= 1'b0;
            src_w      <= ADDRESS_WIDTH'({src_h, src_l});
            dst_w      <= ADDRESS_WIDTH'({dst_h, dst_l});
            cnt_w      <= {cnt_h, cnt_l};
            state      <= dat_i[3] ? S_WAIT_SYNC : S_GAP;
          end
        end

        S_WAIT_SYNC: begin
          // frame_sync is only looked at here, so earlier pulses are intentionally lost
          if (abort_req)       state <= S_IDLE;
          else if (frame_sync) state <= S_GAP;
        end

        S_GAP: begin
          if (abort_req) begin
            state <= S_IDLE;
          end else if (after_read || (cnt_w != '0 && fill_q)) begin
            after_read <= 1'b0;
            m_cyc_o    <= 1'b1;
            m_stb_o    <= 1'b1;
            m_we_o     <= 1'b1;
            m_adr_o    <= dst_w;
            m_dat_o    <= fill_q ? fill_val : data_q;
            state      <= S_WRITE;
          end else if (cnt_w == '0) begin
            done_o <= 1'b1;
            state  <= S_FINISH;
          end else begin
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b0;
            m_adr_o <= src_w;
            state   <= S_READ;
          end
        end

        S_READ: begin
          if (abort_req) abort_pend <= 1'b1;
          if (m_ack_i) begin
            data_q  <= m_dat_i;
            src_w   <= src_w + ADDRESS_WIDTH'(1);
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            if (abort_pend || abort_req) begin
              state <= S_IDLE;
            end else begin
              after_read <= 1'b1;
              state      <= S_GAP;
            end
          end
        end

        S_WRITE: begin
          if (abort_req) abort_pend <= 1'b1;
          if (m_ack_i) begin
            dst_w   <= dst_w + ADDRESS_WIDTH'(1);
            cnt_w   <= cnt_w - CW'(1);
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            state   <= (abort_pend || abort_req) ? S_IDLE : S_GAP;
          end
        end

        S_FINISH: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_dma.sv
`timescale 1ns/1ps
// tb_frame_dma: directed scenarios for frame_dma against a byte memory model
// acting as a zero-wait Wishbone slave with an optional ack hold-off.
module tb_frame_dma;

  localparam logic [15:0] R_CTRL  = 16'h0020;
  localparam logic [15:0] R_SRC_L = 16'h0021;
  localparam logic [15:0] R_SRC_H = 16'h0022;
  localparam logic [15:0] R_DST_L = 16'h0023;
  localparam logic [15:0] R_DST_H = 16'h0024;
  localparam logic [15:0] R_CNT_L = 16'h0025;
  localparam logic [15:0] R_CNT_H = 16'h0026;
  localparam logic [15:0] R_FILL  = 16'h0027;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr = '0;
  logic [7:0]  wdat = '0;
  logic [7:0]  dat_o;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic        ack_o;
  logic [15:0] m_adr_o;
  logic [7:0]  m_dat_o;
  logic [7:0]  s_dat = '0;
  logic        m_we_o, m_stb_o, m_cyc_o;
  logic [0:0]  m_sel_o;
  logic [2:0]  m_cti_o;
  logic        s_ack = 1'b0;
  logic        frame_sync = 1'b0;
  logic        done_o;

  logic [7:0]  mem [0:65535];
  logic        hold_en = 1'b0;
  logic [15:0] hold_adr = '0;

  xfer_t log_q[$];
  int    cyc_cnt = 0, cyc_cycles = 0, done_cnt = 0, done_at = 0;
  int    start_at = 0;
  int    n_cmp = 0, n_err = 0;
  logic [7:0] rd;
  logic       ok, wr_ok;

  always #5 clk = ~clk;

  frame_dma dut (
    .clk_i(clk), .rst_i(rst),
    .adr_i(adr), .dat_i(wdat), .dat_o(dat_o), .we_i(we), .sel_i(1'b1),
    .stb_i(stb), .cyc_i(cyc), .ack_o(ack_o), .cti_i(3'b000),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(s_dat), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_ack_i(s_ack),
    .m_cti_o(m_cti_o), .frame_sync(frame_sync), .done_o(done_o)
  );

  // Memory slave: registered ack one cycle after strobe unless the address is held off.
  always @(posedge clk) begin
    if (rst) begin
      s_ack <= 1'b0;
    end else begin
      s_ack <= m_cyc_o && m_stb_o && !s_ack && !(hold_en && m_adr_o == hold_adr);
      if (m_cyc_o && m_stb_o && !s_ack && !(hold_en && m_adr_o == hold_adr)) begin
        if (m_we_o) mem[m_adr_o] <= m_dat_o;
        s_dat <= mem[m_adr_o];
      end
    end
  end

  // Bus monitor: values seen here belong to the cycle that this edge closes.
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (m_cyc_o && m_stb_o && s_ack)
      log_q.push_back({m_we_o, m_adr_o, m_we_o ? m_dat_o : s_dat});
    if (m_cyc_o) cyc_cycles <= cyc_cycles + 1;
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_at  <= cyc_cnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    adr = a; wdat = d; we = 1'b1; cyc = 1'b1; stb = 1'b1; wr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin wr_ok = 1'b1; break; end
    end
    start_at = cyc_cnt;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [7:0] d, output logic acked);
    @(negedge clk);
    adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1; acked = 1'b0; d = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin acked = 1'b1; d = dat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    wb_write(R_SRC_L, s[7:0]);
    wb_write(R_SRC_H, s[15:8]);
    wb_write(R_DST_L, d[7:0]);
    wb_write(R_DST_H, d[15:8]);
    wb_write(R_CNT_L, n[7:0]);
    wb_write(R_CNT_H, n[15:8]);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({ack_o, m_cyc_o, m_stb_o, m_we_o, done_o} !== 5'b0) begin n_err++;
      $display("FAIL reset_flags: got %b want 00000", {ack_o, m_cyc_o, m_stb_o, m_we_o, done_o}); end
    n_cmp++; if (m_adr_o !== 16'h0000) begin n_err++; $display("FAIL reset_m_adr: got %h want 0000", m_adr_o); end
    n_cmp++; if ({dat_o, m_dat_o} !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", {dat_o, m_dat_o}); end
    n_cmp++; if ({m_sel_o, m_cti_o} !== 4'b1000) begin n_err++; $display("FAIL reset_sel_cti: got %b want 1000", {m_sel_o, m_cti_o}); end
    @(negedge clk); rst = 1'b0;
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if ({ok, rd} !== 9'h100) begin n_err++; $display("FAIL reset_status: got ack=%b %h want ack=1 00", ok, rd); end
  endtask

  task automatic test_copy();
    logic [7:0] vals [4];
    int d0, t0;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      mem[16'h1000 + 16'(i)] = vals[i];
      mem[16'h8000 + 16'(i)] = 8'h00;
    end
    log_q.delete(); d0 = done_cnt;
    program_regs(16'h1000, 16'h8000, 16'd4);
    wb_write(R_CTRL, 8'h01); t0 = start_at;
    wait_done(200); wait_cycles(5);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL copy_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_at - t0 + 1 !== 26) begin n_err++; $display("FAIL copy_latency: got %0d want 26", done_at - t0 + 1); end
    n_cmp++; if (log_q.size() !== 8) begin n_err++; $display("FAIL copy_xfer_count: got %0d want 8", log_q.size()); end
    for (int i = 0; i < 4 && log_q.size() == 8; i++) begin
      n_cmp++; if (log_q[2*i] !== {1'b0, 16'h1000 + 16'(i), vals[i]}) begin n_err++;
        $display("FAIL copy_read[%0d]: got %h want %h", i, log_q[2*i], {1'b0, 16'h1000 + 16'(i), vals[i]}); end
      n_cmp++; if (log_q[2*i+1] !== {1'b1, 16'h8000 + 16'(i), vals[i]}) begin n_err++;
        $display("FAIL copy_write[%0d]: got %h want %h", i, log_q[2*i+1], {1'b1, 16'h8000 + 16'(i), vals[i]}); end
      n_cmp++; if (mem[16'h8000 + 16'(i)] !== vals[i]) begin n_err++;
        $display("FAIL copy_dest[%0d]: got %h want %h", i, mem[16'h8000 + 16'(i)], vals[i]); end
    end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h04) begin n_err++; $display("FAIL copy_status: got %h want 04", rd); end
    wb_read(R_SRC_H, rd, ok);
    n_cmp++; if (rd !== 8'h10) begin n_err++; $display("FAIL copy_src_h_kept: got %h want 10", rd); end
  endtask

  task automatic test_fill();
    int d0, t0, errs;
    for (int i = 0; i < 280; i++) mem[16'h8000 + 16'(i)] = 8'h00;
    mem[16'h8118] = 8'h5A;
    log_q.delete(); d0 = done_cnt; errs = 0;
    wb_write(R_FILL, 8'hA5);
    program_regs(16'h0000, 16'h8000, 16'd280);
    wb_write(R_CTRL, 8'h03); t0 = start_at;
    wait_done(1200); wait_cycles(3);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL fill_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_at - t0 + 1 !== 842) begin n_err++; $display("FAIL fill_latency: got %0d want 842", done_at - t0 + 1); end
    n_cmp++; if (log_q.size() !== 280) begin n_err++; $display("FAIL fill_xfer_count: got %0d want 280", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i] !== {1'b1, 16'h8000 + 16'(i), 8'hA5}) errs++;
    n_cmp++; if (errs !== 0) begin n_err++; $display("FAIL fill_xfers: got %0d bad transfers want 0", errs); end
    n_cmp++; if ({mem[16'h8117], mem[16'h8118]} !== 16'hA55A) begin n_err++;
      $display("FAIL fill_edges: got %h want a55a", {mem[16'h8117], mem[16'h8118]}); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h06) begin n_err++; $display("FAIL fill_status: got %h want 06", rd); end
  endtask

  task automatic test_sync();
    int base, d0;
    mem[16'h9000] = 8'h00;
    d0 = done_cnt;
    program_regs(16'h1000, 16'h9000, 16'd1);
    wb_write(R_CTRL, 8'h09);
    base = cyc_cycles;
    wait_cycles(50);
    n_cmp++; if (cyc_cycles - base !== 0) begin n_err++; $display("FAIL sync_idle_bus: got %0d cyc cycles want 0", cyc_cycles - base); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h09) begin n_err++; $display("FAIL sync_status: got %h want 09", rd); end
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    n_cmp++; if (m_stb_o !== 1'b0) begin n_err++; $display("FAIL sync_gap: got stb=%b want 0", m_stb_o); end
    @(negedge clk);
    n_cmp++; if ({m_stb_o, m_we_o, m_adr_o} !== {2'b10, 16'h1000}) begin n_err++;
      $display("FAIL sync_first_strobe: got %h want %h", {m_stb_o, m_we_o, m_adr_o}, {2'b10, 16'h1000}); end
    wait_done(100);
    n_cmp++; if ({done_cnt - d0, mem[16'h9000]} !== {32'd1, 8'h11}) begin n_err++;
      $display("FAIL sync_result: got done=%0d dest=%h want 1 11", done_cnt - d0, mem[16'h9000]); end
  endtask

  task automatic test_abort();
    int d0;
    logic seen;
    for (int i = 0; i < 10; i++) begin
      mem[16'h2000 + 16'(i)] = 8'h60 + 8'(i);
      mem[16'hA000 + 16'(i)] = 8'h00;
    end
    hold_adr = 16'hA001; hold_en = 1'b1;
    log_q.delete(); d0 = done_cnt; seen = 1'b0;
    program_regs(16'h2000, 16'hA000, 16'd10);
    wb_write(R_CTRL, 8'h01);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_stb_o && m_we_o && m_adr_o == 16'hA001) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL abort_reach_byte2: got %b want 1", seen); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h01) begin n_err++; $display("FAIL abort_busy_status: got %h want 01", rd); end
    wb_write(R_CTRL, 8'h04);
    wait_cycles(12);
    n_cmp++; if ({m_cyc_o, m_stb_o} !== 2'b11) begin n_err++; $display("FAIL abort_held_strobe: got %b want 11", {m_cyc_o, m_stb_o}); end
    @(negedge clk); hold_en = 1'b0;
    wait_cycles(30);
    n_cmp++; if (m_cyc_o !== 1'b0) begin n_err++; $display("FAIL abort_bus_idle: got %b want 0", m_cyc_o); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (log_q.size() !== 4) begin n_err++; $display("FAIL abort_xfer_count: got %0d want 4", log_q.size()); end
    n_cmp++; if ({mem[16'hA001], mem[16'hA002]} !== 16'h6100) begin n_err++;
      $display("FAIL abort_dest: got %h want 6100", {mem[16'hA001], mem[16'hA002]}); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL abort_status: got %h want 00", rd); end
  endtask

  task automatic test_zero_count();
    int d0, t0, base;
    d0 = done_cnt;
    program_regs(16'h3000, 16'hD000, 16'd0);
    base = cyc_cycles;
    wb_write(R_CTRL, 8'h01); t0 = start_at;
    wait_done(20); wait_cycles(3);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_at - t0 + 1 !== 2) begin n_err++; $display("FAIL zero_latency: got %0d want 2", done_at - t0 + 1); end
    n_cmp++; if (cyc_cycles - base !== 0) begin n_err++; $display("FAIL zero_no_bus: got %0d want 0", cyc_cycles - base); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h04) begin n_err++; $display("FAIL zero_status: got %h want 04", rd); end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h88;
    mem[16'hB000] = 8'h00; mem[16'hB001] = 8'h00;
    log_q.delete();
    program_regs(16'hFFFF, 16'hB000, 16'd2);
    wb_write(R_CTRL, 8'h01);
    wait_done(100); wait_cycles(2);
    n_cmp++; if (log_q.size() !== 4) begin n_err++; $display("FAIL wrap_xfer_count: got %0d want 4", log_q.size()); end
    n_cmp++; if (log_q[0] !== {1'b0, 16'hFFFF, 8'h77}) begin n_err++; $display("FAIL wrap_read0: got %h want 0ffff77", log_q[0]); end
    n_cmp++; if (log_q[2] !== {1'b0, 16'h0000, 8'h88}) begin n_err++; $display("FAIL wrap_read1: got %h want 0000088", log_q[2]); end
    n_cmp++; if (mem[16'hB001] !== 8'h88) begin n_err++; $display("FAIL wrap_dest: got %h want 88", mem[16'hB001]); end
  endtask

  task automatic test_back_to_back();
    int d0;
    for (int i = 0; i < 4; i++) mem[16'hC000 + 16'(i)] = 8'h00;
    log_q.delete(); d0 = done_cnt;
    program_regs(16'h1000, 16'hC000, 16'd3);
    wb_write(R_CTRL, 8'h01);
    wait_cycles(4);
    wb_write(R_SRC_L, 8'h55);
    wb_write(R_CTRL, 8'h03);
    wait_done(200); wait_cycles(20);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL busy_done_pulses: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (log_q.size() !== 6) begin n_err++; $display("FAIL busy_xfer_count: got %0d want 6", log_q.size()); end
    n_cmp++; if ({mem[16'hC000], mem[16'hC001], mem[16'hC002], mem[16'hC003]} !== 32'h11223300) begin n_err++;
      $display("FAIL busy_dest: got %h want 11223300", {mem[16'hC000], mem[16'hC001], mem[16'hC002], mem[16'hC003]}); end
    wb_read(R_SRC_L, rd, ok);
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL busy_reg_write_ignored: got %h want 00", rd); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h04) begin n_err++; $display("FAIL busy_status: got %h want 04", rd); end
  endtask

  task automatic test_no_ack();
    wb_read(16'h0028, rd, ok);
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL noack_reg8: got ack=%b want 0", ok); end
    wb_read(16'h0030, rd, ok);
    n_cmp++; if (ok !== 1'b0) begin n_err++; $display("FAIL noack_outside: got ack=%b want 0", ok); end
    wb_write(16'h0031, 8'hEE);
    n_cmp++; if (wr_ok !== 1'b0) begin n_err++; $display("FAIL noack_outside_write: got ack=%b want 0", wr_ok); end
    wb_read(R_SRC_L, rd, ok);
    n_cmp++; if ({ok, rd} !== 9'h100) begin n_err++; $display("FAIL noack_src_untouched: got ack=%b %h want ack=1 00", ok, rd); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    int base;
    seen = 1'b0;
    program_regs(16'h1000, 16'hE000, 16'd5);
    wb_write(R_CTRL, 8'h01);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_stb_o && !m_we_o) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rstmid_reach_read: got %b want 1", seen); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({m_cyc_o, m_stb_o, m_we_o, done_o, ack_o} !== 5'b0) begin n_err++;
      $display("FAIL rstmid_flags: got %b want 00000", {m_cyc_o, m_stb_o, m_we_o, done_o, ack_o}); end
    n_cmp++; if ({m_adr_o, m_dat_o, dat_o} !== 32'h0) begin n_err++;
      $display("FAIL rstmid_values: got %h want 00000000", {m_adr_o, m_dat_o, dat_o}); end
    @(negedge clk); rst = 1'b0;
    base = cyc_cycles;
    wait_cycles(10);
    n_cmp++; if (cyc_cycles - base !== 0) begin n_err++; $display("FAIL rstmid_no_bus: got %0d want 0", cyc_cycles - base); end
    wb_read(R_CTRL, rd, ok);
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL rstmid_status: got %h want 00", rd); end
    wb_read(R_CNT_L, rd, ok);
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL rstmid_count_cleared: got %h want 00", rd); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_sync();
    test_abort();
    test_zero_count();
    test_wrap();
    test_back_to_back();
    test_no_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
